// File: rtl/regbank_wb_pkg.sv
// Shared constants for the writeback register bank.
//   REG_ZERO         : hard-wired zero register number
//   RA_REG           : return-address register written by jal
//   DATA_WIDTH_DEF   : default register width
//   ADDR_WIDTH_DEF   : default register-number width
package regbank_wb_pkg;
  localparam int REG_ZERO       = 0;
  localparam int RA_REG         = 31;
  localparam int DATA_WIDTH_DEF = 32;
  localparam int ADDR_WIDTH_DEF = 5;
endpackage

// File: rtl/regbank_bypass.sv
// Read-priority mux for one register-file read port.
// Priority: register zero, same-cycle writeback, staged write, array.
// Ports:
//   raddr    : register number being read
//   wr_en    : incoming writeback enable (already qualified by reset)
//   waddr    : incoming writeback register number
//   wdata    : incoming writeback data
//   stg_vld  : staging register holds an uncommitted write
//   stg_addr : staged register number
//   stg_data : staged data
//   arr_data : committed array contents at raddr
//   rdata    : resolved read data
module regbank_bypass
  import regbank_wb_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic [ADDR_WIDTH-1:0] raddr,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  stg_vld,
  input  logic [ADDR_WIDTH-1:0] stg_addr,
  input  logic [DATA_WIDTH-1:0] stg_data,
  input  logic [DATA_WIDTH-1:0] arr_data,
  output logic [DATA_WIDTH-1:0] rdata
);

  always_comb begin
    rdata = arr_data;
    if (raddr == ADDR_WIDTH'(REG_ZERO)) begin
      rdata = '0;
    end else if (wr_en && (waddr == raddr)) begin
      rdata = wdata;
    end else if (stg_vld && (stg_addr == raddr)) begin
      rdata = stg_data;
    end
  end

endmodule

// File: rtl/regbank_wb.sv
// MIPS general-purpose register file with a one-deep write staging
// register and full bypass to both read ports and the RA mirror.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   we_i/waddr_i/wdata_i: writeback enable, register number, data
//   raddr_a_i/rdata_a_o : read port A (rs)
//   raddr_b_i/rdata_b_o : read port B (rt)
//   ra_o                : bypassed architectural value of RA_REG
//   pend_o              : staging register holds an uncommitted write
module regbank_wb #(
  parameter int DATA_WIDTH = regbank_wb_pkg::DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = regbank_wb_pkg::ADDR_WIDTH_DEF,
  parameter int RA_REG     = regbank_wb_pkg::RA_REG
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_a_i,
  input  logic [ADDR_WIDTH-1:0] raddr_b_i,
  output logic [DATA_WIDTH-1:0] rdata_a_o,
  output logic [DATA_WIDTH-1:0] rdata_b_o,
  output logic [DATA_WIDTH-1:0] ra_o,
  output logic                  pend_o
);
  import regbank_wb_pkg::*;

  localparam int NREGS = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] RA_ADDR = ADDR_WIDTH'(RA_REG);

  logic [DATA_WIDTH-1:0] regs [NREGS];

  logic                  vld_p1;
  logic [ADDR_WIDTH-1:0] addr_p1;
  logic [DATA_WIDTH-1:0] data_p1;

  logic                  wr_p0;
  logic                  byp_en;

  // Writes to register zero never enter the staging register.
  assign wr_p0  = we_i && (waddr_i != ADDR_WIDTH'(REG_ZERO));
  // While reset is held the incoming writeback must not leak onto the reads.
  assign byp_en = we_i && rst_n;

  // ---- stage p0 -> p1: capture writeback into the staging register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      addr_p1 <= '0;
      data_p1 <= '0;
    end else begin
      vld_p1 <= wr_p0;
      if (wr_p0) begin
        addr_p1 <= waddr_i;
        data_p1 <= wdata_i;
      end
    end
  end

  // ---- stage p1 -> array: commit the staged write ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (vld_p1) begin
      regs[addr_p1] <= data_p1;
    end
  end

  assign pend_o = vld_p1;

  regbank_bypass #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_byp_a (
    .raddr    (raddr_a_i),
    .wr_en    (byp_en),
    .waddr    (waddr_i),
    .wdata    (wdata_i),
    .stg_vld  (vld_p1),
    .stg_addr (addr_p1),
    .stg_data (data_p1),
    .arr_data (regs[raddr_a_i]),
    .rdata    (rdata_a_o)
  );

  regbank_bypass #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_byp_b (
    .raddr    (raddr_b_i),
    .wr_en    (byp_en),
    .waddr    (waddr_i),
    .wdata    (wdata_i),
    .stg_vld  (vld_p1),
    .stg_addr (addr_p1),
    .stg_data (data_p1),
    .arr_data (regs[raddr_b_i]),
    .rdata    (rdata_b_o)
  );

  regbank_bypass #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_byp_ra (
    .raddr    (RA_ADDR),
    .wr_en    (byp_en),
    .waddr    (waddr_i),
    .wdata    (wdata_i),
    .stg_vld  (vld_p1),
    .stg_addr (addr_p1),
    .stg_data (data_p1),
    .arr_data (regs[RA_ADDR]),
    .rdata    (ra_o)
  );

endmodule
